dmem_access_unit: RTL and testbench
===================================

Name: dmem_access_unit

Overview:
Load/store initiator that drives the byte-banked synchronous data memory (write port A, read port B, 1-cycle read latency, unaligned access handled by the memory).
- Accepts one access at a time from the CPU execute stage over a valid/ready request channel.
- Generates byte enables, bounds-checks the address, and aligns, masks and sign-extends load data.
- Returns a registered response over a valid/ready response channel.

Parameters:
ADDRESS_WIDTH, 32, width of request and memory addresses
DATA_WIDTH, 32, data width; BANK_NUM = DATA_WIDTH/8 = 4
ADDRESS_LIMIT, 4096, byte size of the memory; accesses touching bytes at or above this fault

Ports:
i_clk  in  1  clock
i_rst  in  1  reset
i_req_valid  in  1  request valid
o_req_ready  out  1  request ready
i_req_we  in  1  1=store, 0=load
i_req_size  in  2  0=byte, 1=half, 2=word, 3=reserved
i_req_signed  in  1  sign-extend load result
i_req_addr  in  ADDRESS_WIDTH  byte address, any alignment
i_req_wdata  in  DATA_WIDTH  store data, low bytes significant
o_resp_valid  out  1  response valid
i_resp_ready  in  1  response accepted
o_resp_rdata  out  DATA_WIDTH  load result (0 for stores/faults)
o_resp_fault  out  1  access fault
o_mea  out  1  memory write select
o_wea  out  BANK_NUM  memory byte write enables
o_adra  out  ADDRESS_WIDTH  memory write address
o_da  out  DATA_WIDTH  memory write data
o_meb  out  1  memory read select
o_adrb  out  ADDRESS_WIDTH  memory read address
i_qb  in  DATA_WIDTH  memory read data, valid one cycle after o_meb

Behaviour:
- One clock i_clk; reset i_rst is asynchronous, active-high. It forces state IDLE and clears o_resp_valid, o_resp_rdata, o_resp_fault and all registered request fields to 0.
- While i_rst is high: o_req_ready=0, o_mea=0, o_meb=0.
- nbytes = 1/2/4 for size 0/1/2.
- fault = (size==3) or (addr + nbytes > ADDRESS_LIMIT). The sum is computed at ADDRESS_WIDTH+1 bits, so no wrap-around.
- States: IDLE, READ, RESP.
- IDLE: o_req_ready=1. A request is accepted on i_req_valid & o_req_ready.
  - Store, no fault: same cycle, o_mea=1, o_adra=addr, o_da=wdata, o_wea = 0001/0011/1111 for byte/half/word (the memory rotates enables for unaligned addresses). Next state RESP, rdata=0, fault=0.
  - Load, no fault: same cycle, o_meb=1, o_adrb=addr; latch size and signed. Next state READ.
  - Fault, either direction: no memory enable asserted. Next state RESP, fault=1, rdata=0.
- Memory strobes are combinational and are never asserted outside an accepted request. o_adra, o_adrb and o_da follow i_req_addr and i_req_wdata; their values are don't-care when the enables are low.
- READ: capture i_qb.
  - byte: bits[7:0], extended from bit 7.
  - half: bits[15:0], extended from bit 15.
  - word: unchanged.
  - Extension is sign if signed=1, else zero.
  - Next state RESP. o_req_ready=0.
- RESP: o_resp_valid=1. Outputs stay stable until i_resp_ready; on handshake, next state IDLE. o_req_ready=0 in RESP (no same-cycle overlap).
- Latency from acceptance to o_resp_valid: load 2 cycles, store/fault 1 cycle.
- Throughput is one access per 3 cycles (load) or 2 cycles (store) when i_resp_ready is held high.
- i_req_* is sampled only at the acceptance cycle; later changes have no effect.
- Reset asserted in READ or RESP: the in-flight response is dropped. A store already accepted is considered performed.

Test Plan:
- Store word 0xDEADBEEF @0x10, then load word @0x10 -> o_wea=1111 at accept; load response 0xDEADBEEF, fault=0, o_resp_valid exactly 2 cycles after load accept.
- Store half 0xA5F0 @0x21 (unaligned), then load half signed @0x21 -> o_wea=0011; rdata=0xFFFFA5F0. Unsigned load gives 0x0000A5F0.
- Store byte 0x80 @0x7, then load byte signed/unsigned -> 0xFFFFFF80 / 0x00000080; neighbouring bytes @0x6 and @0x8 unchanged.
- Load word @0xFFD with ADDRESS_LIMIT=4096 -> fault=1, rdata=0, o_meb never asserted. Load word @0xFFC -> no fault. Size=3 -> fault.
- Hold i_resp_ready=0 for 5 cycles in RESP with i_req_valid=1 -> o_resp_* stable, o_req_ready=0, no memory enables; the next request is accepted the cycle after the response handshake.
- Assert i_rst asynchronously in READ -> o_resp_valid=0 immediately; after release, state IDLE and o_req_ready=1; a new load completes normally.

Source files
------------

// File: rtl/dmem_access_unit.sv
// Load/store initiator for a byte-banked synchronous data memory.
// One access in flight: request accept -> (READ for loads) -> registered response.
module dmem_access_unit #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_LIMIT = 4096
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_req_valid,
  output logic                     o_req_ready,
  input  logic                     i_req_we,
  input  logic [1:0]               i_req_size,
  input  logic                     i_req_signed,
  input  logic [ADDRESS_WIDTH-1:0] i_req_addr,
  input  logic [DATA_WIDTH-1:0]    i_req_wdata,
  output logic                     o_resp_valid,
  input  logic                     i_resp_ready,
  output logic [DATA_WIDTH-1:0]    o_resp_rdata,
  output logic                     o_resp_fault,
  output logic                     o_mea,
  output logic [DATA_WIDTH/8-1:0]  o_wea,
  output logic [ADDRESS_WIDTH-1:0] o_adra,
  output logic [DATA_WIDTH-1:0]    o_da,
  output logic                     o_meb,
  output logic [ADDRESS_WIDTH-1:0] o_adrb,
  input  logic [DATA_WIDTH-1:0]    i_qb
);

  localparam int BANK_NUM = DATA_WIDTH / 8;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; the sender holds its payload stable until that edge.
  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, RESP = 2'd2} state_e;

  state_e                  state_q, state_d;
  logic [1:0]              size_q, size_d;
  logic                    signed_q, signed_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    fault_q, fault_d;

  logic [ADDRESS_WIDTH:0]  nbytes;
  logic [ADDRESS_WIDTH:0]  end_addr;
  logic                    req_fault;
  logic [BANK_NUM-1:0]     wea_w;
  logic [DATA_WIDTH-1:0]   load_data;

  // End address is one bit wider than the address so top-of-space accesses cannot wrap.
  always_comb begin
    nbytes = (ADDRESS_WIDTH+1)'(4);
    wea_w  = '1;
    case (i_req_size)
      2'd0: begin nbytes = (ADDRESS_WIDTH+1)'(1); wea_w = BANK_NUM'(1); end
      2'd1: begin nbytes = (ADDRESS_WIDTH+1)'(2); wea_w = BANK_NUM'(3); end
      default: ;
    endcase
    end_addr  = {1'b0, i_req_addr} + nbytes;
    req_fault = (i_req_size == 2'd3) ||
                (end_addr > (ADDRESS_WIDTH+1)'(ADDRESS_LIMIT));
  end

  always_comb begin
    load_data = i_qb;
    case (size_q)
      2'd0: load_data = {{(DATA_WIDTH-8){signed_q & i_qb[7]}}, i_qb[7:0]};
      2'd1: load_data = {{(DATA_WIDTH-16){signed_q & i_qb[15]}}, i_qb[15:0]};
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    size_d      = size_q;
    signed_d    = signed_q;
    rdata_d     = rdata_q;
    fault_d     = fault_q;
    o_req_ready = 1'b0;
    o_mea       = 1'b0;
    o_meb       = 1'b0;
    o_wea       = '0;
    unique case (state_q)
      IDLE: begin
        // Ready is masked during reset so no strobe can escape while reset is held.
        o_req_ready = !i_rst;
        if (i_req_valid && !i_rst) begin
          rdata_d = '0;
          fault_d = req_fault;
          if (req_fault) begin
            state_d = RESP;
          end else if (i_req_we) begin
            o_mea   = 1'b1;
            o_wea   = wea_w;
            state_d = RESP;
          end else begin
            o_meb    = 1'b1;
            size_d   = i_req_size;
            signed_d = i_req_signed;
            state_d  = READ;
          end
        end
      end
      READ: begin
        rdata_d = load_data;
        fault_d = 1'b0;
        state_d = RESP;
      end
      RESP: begin
        if (i_resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= IDLE;
      size_q   <= 2'd0;
      signed_q <= 1'b0;
      rdata_q  <= '0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      rdata_q  <= rdata_d;
      fault_q  <= fault_d;
    end
  end

  assign o_adra       = i_req_addr;
  assign o_adrb       = i_req_addr;
  assign o_da         = i_req_wdata;
  assign o_resp_valid = (state_q == RESP);
  assign o_resp_rdata = rdata_q;
  assign o_resp_fault = fault_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Bench for dmem_access_unit: behavioural byte memory, vector table, scoreboard
// of expected {fault, rdata}, plus stall and mid-flight reset sequences.
module tb_dmem_access_unit;

  logic        i_clk, i_rst;
  logic        i_req_valid, o_req_ready, i_req_we, i_req_signed;
  logic [1:0]  i_req_size;
  logic [31:0] i_req_addr, i_req_wdata;
  logic        o_resp_valid, i_resp_ready, o_resp_fault;
  logic [31:0] o_resp_rdata;
  logic        o_mea, o_meb;
  logic [3:0]  o_wea;
  logic [31:0] o_adra, o_da, o_adrb, i_qb;

  dmem_access_unit #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .ADDRESS_LIMIT(4096)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_we(i_req_we), .i_req_size(i_req_size), .i_req_signed(i_req_signed),
    .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
    .o_resp_valid(o_resp_valid), .i_resp_ready(i_resp_ready),
    .o_resp_rdata(o_resp_rdata), .o_resp_fault(o_resp_fault),
    .o_mea(o_mea), .o_wea(o_wea), .o_adra(o_adra), .o_da(o_da),
    .o_meb(o_meb), .o_adrb(o_adrb), .i_qb(i_qb)
  );

  // clock / reset
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // behavioural memory: byte i of a beat lives at address+i (unaligned handled here)
  logic [7:0] mem [4096];
  logic [7:0] sh  [4096];
  always @(posedge i_clk) begin
    if (o_mea)
      for (int b = 0; b < 4; b++)
        if (o_wea[b]) mem[12'(o_adra + 32'(b))] <= o_da[8*b +: 8];
    if (o_meb)
      for (int b = 0; b < 4; b++) i_qb[8*b +: 8] <= mem[12'(o_adrb + 32'(b))];
  end

  // scoreboard
  int total = 0;
  int bad   = 0;
  logic [32:0] exp_q[$];
  logic [32:0] mon_e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge i_clk) begin
    #2;
    if (!i_rst && o_resp_valid && i_resp_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_resp: got rdata 0x%0h with empty queue", o_resp_rdata);
      end else begin
        mon_e = exp_q.pop_front();
        chk("resp_rdata", o_resp_rdata, mon_e[31:0]);
        chk("resp_fault", o_resp_fault, mon_e[32]);
      end
    end
  end

  function automatic logic [31:0] model_ld(input logic [1:0] size, input logic sgn,
                                           input logic [31:0] addr);
    logic [31:0] w;
    for (int b = 0; b < 4; b++) w[8*b +: 8] = sh[12'(addr + 32'(b))];
    case (size)
      2'd0: model_ld = {{24{sgn & w[7]}}, w[7:0]};
      2'd1: model_ld = {{16{sgn & w[15]}}, w[15:0]};
      default: model_ld = w;
    endcase
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (o_resp_valid && n < 20) begin @(negedge i_clk); #1; n++; end
    if (o_resp_valid) chk("resp_drain_timeout", 1, 0);
  endtask

  // driver: one request, strobe checks at accept, latency check, wait for response
  task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_fault);
    int n = 0;
    int lat = 0;
    logic exp_mea, exp_meb;
    logic [3:0] exp_wea;
    @(negedge i_clk);
    i_req_we = we; i_req_size = size; i_req_signed = sgn;
    i_req_addr = addr; i_req_wdata = wdata; i_req_valid = 1'b1;
    #1;
    while (!o_req_ready && n < 20) begin @(negedge i_clk); #1; n++; end
    if (!o_req_ready) chk("req_ready_timeout", o_req_ready, 1);
    exp_mea = we & ~exp_fault;
    exp_meb = ~we & ~exp_fault;
    exp_wea = (size == 2'd0) ? 4'b0001 : (size == 2'd1) ? 4'b0011 : 4'b1111;
    chk("mea", o_mea, exp_mea);
    chk("meb", o_meb, exp_meb);
    if (exp_mea) begin
      chk("wea", o_wea, exp_wea);
      chk("adra", o_adra, addr);
      chk("da", o_da, wdata);
      for (int b = 0; b < (1 << size); b++) sh[12'(addr + 32'(b))] = wdata[8*b +: 8];
    end
    if (exp_meb) chk("adrb", o_adrb, addr);
    exp_q.push_back({exp_fault, exp_rdata});
    @(posedge i_clk); #1;
    i_req_valid = 1'b0;
    i_req_we = 1'($urandom); i_req_size = 2'($urandom_range(0, 3));
    i_req_signed = 1'($urandom); i_req_addr = $urandom; i_req_wdata = $urandom;
    while (lat < 10) begin
      @(negedge i_clk); #1; lat++;
      if (o_resp_valid) break;
    end
    chk("latency", 64'(lat), (we | exp_fault) ? 64'd1 : 64'd2);
    wait_idle();
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_fault;
  } vec_t;

  vec_t vecs[18];

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem[i] = 8'(i) ^ 8'h5A;
      sh[i]  = 8'(i) ^ 8'h5A;
    end
    vecs[0]  = '{1'b1, 2'd2, 1'b0, 32'h010, 32'hDEADBEEF, 32'h0, 1'b0};
    vecs[1]  = '{1'b0, 2'd2, 1'b0, 32'h010, 32'h0, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 2'd1, 1'b0, 32'h021, 32'h1234A5F0, 32'h0, 1'b0};
    vecs[3]  = '{1'b0, 2'd1, 1'b1, 32'h021, 32'h0, 32'hFFFFA5F0, 1'b0};
    vecs[4]  = '{1'b0, 2'd1, 1'b0, 32'h021, 32'h0, 32'h0000A5F0, 1'b0};
    vecs[5]  = '{1'b1, 2'd0, 1'b0, 32'h007, 32'hFFFFFF80, 32'h0, 1'b0};
    vecs[6]  = '{1'b0, 2'd0, 1'b1, 32'h007, 32'h0, 32'hFFFFFF80, 1'b0};
    vecs[7]  = '{1'b0, 2'd0, 1'b0, 32'h007, 32'h0, 32'h00000080, 1'b0};
    vecs[8]  = '{1'b0, 2'd0, 1'b0, 32'h006, 32'h0, 32'h0000005C, 1'b0};
    vecs[9]  = '{1'b0, 2'd0, 1'b0, 32'h008, 32'h0, 32'h00000052, 1'b0};
    vecs[10] = '{1'b0, 2'd2, 1'b0, 32'hFFD, 32'h0, 32'h0, 1'b1};
    vecs[11] = '{1'b0, 2'd2, 1'b0, 32'hFFC, 32'h0, 32'hA5A4A7A6, 1'b0};
    vecs[12] = '{1'b0, 2'd3, 1'b0, 32'h000, 32'h0, 32'h0, 1'b1};
    vecs[13] = '{1'b1, 2'd2, 1'b0, 32'hFFE, 32'hCAFEF00D, 32'h0, 1'b1};
    vecs[14] = '{1'b0, 2'd1, 1'b0, 32'hFFE, 32'h0, 32'h0000A5A4, 1'b0};
    vecs[15] = '{1'b0, 2'd0, 1'b1, 32'hFFF, 32'h0, 32'hFFFFFFA5, 1'b0};
    vecs[16] = '{1'b1, 2'd3, 1'b0, 32'h100, 32'h12345678, 32'h0, 1'b1};
    vecs[17] = '{1'b0, 2'd0, 1'b0, 32'hFFFFFFFF, 32'h0, 32'h0, 1'b1};

    i_rst = 1'b1; i_req_valid = 1'b0; i_req_we = 1'b0; i_req_size = 2'd0;
    i_req_signed = 1'b0; i_req_addr = '0; i_req_wdata = '0; i_resp_ready = 1'b1;
    #12;
    chk("rst_req_ready", o_req_ready, 0);
    chk("rst_resp_valid", o_resp_valid, 0);
    chk("rst_rdata", o_resp_rdata, 0);
    chk("rst_fault", o_resp_fault, 0);
    chk("rst_mea", o_mea, 0);
    chk("rst_meb", o_meb, 0);
    @(negedge i_clk); i_rst = 1'b0; #1;
    chk("post_rst_ready", o_req_ready, 1);

    for (int i = 0; i < 18; i++)
      do_req(vecs[i].we, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata,
             vecs[i].exp_rdata, vecs[i].exp_fault);

    // response stall with a new request waiting
    i_resp_ready = 1'b0;
    @(negedge i_clk);
    i_req_we = 1'b0; i_req_size = 2'd2; i_req_signed = 1'b0;
    i_req_addr = 32'h10; i_req_valid = 1'b1;
    #1;
    chk("stall_accept_ready", o_req_ready, 1);
    chk("stall_accept_meb", o_meb, 1);
    exp_q.push_back({1'b0, 32'hDEADBEEF});
    @(posedge i_clk); #1;
    i_req_we = 1'b1; i_req_addr = 32'h40; i_req_wdata = 32'h11111111;
    repeat (2) @(negedge i_clk);
    #1;
    chk("stall_resp_valid", o_resp_valid, 1);
    for (int k = 0; k < 5; k++) begin
      chk("stall_valid", o_resp_valid, 1);
      chk("stall_rdata", o_resp_rdata, 32'hDEADBEEF);
      chk("stall_fault", o_resp_fault, 0);
      chk("stall_req_ready", o_req_ready, 0);
      chk("stall_mea", o_mea, 0);
      chk("stall_meb", o_meb, 0);
      @(negedge i_clk); #1;
    end
    i_resp_ready = 1'b1;
    @(posedge i_clk); #1;
    chk("post_hs_ready", o_req_ready, 1);
    chk("post_hs_mea", o_mea, 1);
    for (int b = 0; b < 4; b++) sh[12'(32'h40 + 32'(b))] = 8'h11;
    exp_q.push_back({1'b0, 32'h0});
    @(posedge i_clk); #1;
    i_req_valid = 1'b0;
    wait_idle();
    do_req(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 32'h11111111, 1'b0);

    // asynchronous reset while a load is in READ
    @(negedge i_clk);
    i_req_we = 1'b0; i_req_size = 2'd2; i_req_addr = 32'h10; i_req_valid = 1'b1;
    exp_q.push_back({1'b0, 32'hDEADBEEF});
    @(posedge i_clk); #1;
    i_req_valid = 1'b0;
    #2; i_rst = 1'b1; #1;
    void'(exp_q.pop_back());
    chk("rst_read_valid", o_resp_valid, 0);
    chk("rst_read_ready", o_req_ready, 0);
    chk("rst_read_meb", o_meb, 0);
    @(negedge i_clk); #1;
    chk("rst_hold_valid", o_resp_valid, 0);
    i_rst = 1'b0; #1;
    chk("rst_rel_ready", o_req_ready, 1);
    chk("rst_rel_valid", o_resp_valid, 0);
    do_req(1'b0, 2'd1, 1'b0, 32'h21, 32'h0, 32'h0000A5F0, 1'b0);

    // random aligned/unaligned traffic against the shadow model
    for (int i = 0; i < 24; i++) begin
      logic        we, sgn;
      logic [1:0]  size;
      logic [31:0] addr, wd;
      we   = 1'($urandom);
      sgn  = 1'($urandom);
      size = 2'($urandom_range(0, 2));
      addr = 32'h100 + 32'($urandom_range(0, 63));
      wd   = $urandom;
      do_req(we, size, sgn, addr, wd, we ? 32'h0 : model_ld(size, sgn, addr), 1'b0);
    end

    repeat (3) @(negedge i_clk);
    chk("queue_drained", 64'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
